npu_mac_sequencer: RTL
======================

Name: npu_mac_sequencer

Overview:
Cycle-level controller that runs one K×K convolution window on the PE array.
- On a start command it clears the PE accumulators, then steps the weight mux select (A) and input mux select (B) through all taps with the PEs enabled, drains the PE pipeline, and signals done.
- It sits between the memory-mapped command path and the PE array's mux/enable controls.
- It replaces per-tap software instruction writes with a single start.

Parameters:
N, 10, number of PE lanes
K_SIZE, 3, kernel side; MAX_TAPS = K_SIZE*K_SIZE (localparam, 9)
SEL_MUX_A_WIDTH, 4, weight-mux select width
SEL_MUX_B_WIDTH, 5, input-mux select width
DRAIN_CYCLES, 2, idle cycles after the last MAC before done (PE pipeline depth); legal range 0..7

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  start request, sampled each cycle
abort_i  input  1  abort current run
cfg_mask_i  input  N  lanes to run
cfg_mode_i  input  1  0 = broadcast input bank, 1 = direct per-PE input bank
cfg_taps_i  input  4  number of taps to run
pe_en_o  output  N  PE MAC enable
pe_mode_sel_o  output  N  PE mode select
pe_reg_reset_o  output  N  PE accumulator clear
mux_a_sel_o  output  SEL_MUX_A_WIDTH  weight tap select
mux_b_sel_o  output  SEL_MUX_B_WIDTH  input tap select
busy_o  output  1  run in progress
done_o  output  1  one-cycle completion pulse
perf_mac_cycles_o  output  16  MAC-cycle counter (optional feature)

Behaviour:
Reset and registering
- Reset: every output is 0; state is IDLE.
- All outputs are registered.

States and transitions
- States are IDLE, CLEAR, MAC, DRAIN, DONE.
- IDLE: a start is accepted when start_i=1.
  - Accepting a start latches cfg_mask, cfg_mode and taps, then moves to CLEAR.
  - taps = cfg_taps_i, except 0 or a value > MAX_TAPS is clamped to MAX_TAPS.
- start_i outside IDLE is ignored; the run is not restarted and no error is raised.
- CLEAR (1 cycle): pe_reg_reset_o = mask, pe_en_o = 0; then MAC with tap = 0.
- MAC (taps cycles):
  - pe_en_o = mask, mux_a_sel_o = tap.
  - mux_b_sel_o = tap when mode = 0, tap + MAX_TAPS when mode = 1. The B-mux low half is the broadcast bank; the high half is the direct bank.
  - tap increments each cycle. After tap = taps-1 the next state is DRAIN, or DONE if DRAIN_CYCLES = 0.
- DRAIN (DRAIN_CYCLES cycles): pe_en_o = 0; the selects hold their last value; then DONE.
- DONE (1 cycle): done_o = 1; then IDLE.
  - A start asserted in the DONE cycle is ignored; it must be held into IDLE.

Output behaviour by state
- pe_mode_sel_o = {N{mode}} AND mask from CLEAR through DONE, and 0 in IDLE.
- busy_o = 1 in CLEAR, MAC, DRAIN and DONE.
- mux selects are 0 in IDLE.

Latency
- start sampled at cycle T gives: CLEAR at T+1, MAC T+2..T+1+taps, done at T+2+taps+DRAIN_CYCLES.

Abort
- abort_i in any non-IDLE state forces IDLE on the next edge. All outputs go to 0 and no done pulse is produced.
- abort_i takes priority over start_i and over state advance.
- abort_i in IDLE has no effect.

Other boundaries
- cfg_mask_i = 0 runs the full timing with all enables 0, and done is still pulsed.
- Reset mid-run returns immediately to the reset values.

Optional Feature:
Macro NPU_SEQ_PERF_CNT_EN.
- Defined: perf_mac_cycles_o increments by 1 in every MAC-state cycle.
  - It saturates at 0xFFFF.
  - It is cleared only by rst_n, not by abort.
- Undefined: no counter logic exists and perf_mac_cycles_o is constant 0. The port is always present.

Decomposition:
- Package npu_pkg holds:
  - the state enum npu_seq_state_t (IDLE, CLEAR, MAC, DRAIN, DONE)
  - localparam MAX_TAPS
  - localparam B_DIRECT_OFFSET = MAX_TAPS
  - the taps-clamp function
- One natural sub-module: npu_seq_tap_counter. It is a loadable tap counter with terminal-count flag, reused for the DRAIN countdown.
- The FSM and output registers stay in the top.

Test Plan:
- Direct run: mask = 0x3FF, mode = 1, taps = 9, start at T0.
  - pe_reg_reset = 0x3FF at T1.
  - pe_en = 0x3FF at T2–T10, with mux_a 0..8 and mux_b 9..17.
  - done at T13.
  - busy stays high T1–T13.
- Broadcast, partial: mask = 0x005, mode = 0, taps = 4.
  - pe_en = 0x005 for 4 cycles with mux_b 0..3.
  - pe_mode_sel = 0.
  - done at T8.
- Clamp: taps = 0 and taps = 12 each produce exactly 9 MAC cycles, with mux_a ending at 8.
- Abort: abort_i at T5 of a 9-tap run.
  - All outputs are 0 at T6 and no done pulse occurs.
  - A new start at T7 runs normally.
- Start while busy: start_i pulsed at T4 and at the DONE cycle → ignored. A second run occurs only when start is re-asserted in IDLE.
- Perf counter (macro defined): two 9-tap runs plus one aborted after 3 MAC cycles → perf_mac_cycles_o = 21. With the macro undefined the output reads 0.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU MAC sequencer.
// Contents: FSM state enum, tap-count constants, taps clamp helper.
package npu_pkg;

  localparam int unsigned K_SIZE          = 3;
  localparam int unsigned MAX_TAPS        = K_SIZE * K_SIZE;
  localparam int unsigned B_DIRECT_OFFSET = MAX_TAPS;
  localparam int unsigned TAP_W           = 4;
  localparam int unsigned PERF_W          = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } npu_seq_state_t;

  // Zero or over-range tap requests run the full kernel window.
  function automatic logic [TAP_W-1:0] clamp_taps(input logic [TAP_W-1:0] taps);
    if ((taps == '0) || (taps > TAP_W'(MAX_TAPS)))
      return TAP_W'(MAX_TAPS);
    return taps;
  endfunction

endpackage

// File: rtl/npu_seq_tap_counter.sv
// Loadable up-counter with terminal-count flag; sequences MAC taps and the
// DRAIN countdown.
// Ports: clk, rst_n, load (count <= load_val), inc (count + 1),
//        term_val (terminal value), count (registered), last_c (count == term_val).
module npu_seq_tap_counter
  import npu_pkg::*;
#(
  parameter int unsigned W = TAP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         last_c
);

  // Load wins over increment so a new phase always starts from load_val.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (inc)
      count <= count + W'(1);
  end

  assign last_c = (count == term_val);

endmodule

// File: rtl/npu_mac_sequencer.sv
// Runs one KxK convolution window on the PE array from a single start:
// clear accumulators, step weight/input mux selects through the taps with
// PEs enabled, drain the PE pipeline, pulse done.
// Ports: clk, rst_n; start_i, abort_i; cfg_mask_i/cfg_mode_i/cfg_taps_i
//        (latched at start); pe_en_o, pe_mode_sel_o, pe_reg_reset_o,
//        mux_a_sel_o, mux_b_sel_o, busy_o, done_o, perf_mac_cycles_o.
// Optional: define NPU_SEQ_PERF_CNT_EN to enable the saturating MAC-cycle
//           counter; otherwise perf_mac_cycles_o is tied to 0.
module npu_mac_sequencer
  import npu_pkg::*;
#(
  parameter int unsigned N               = 10,
  parameter int unsigned SEL_MUX_A_WIDTH = 4,
  parameter int unsigned SEL_MUX_B_WIDTH = 5,
  parameter int unsigned DRAIN_CYCLES    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [N-1:0]               cfg_mask_i,
  input  logic                       cfg_mode_i,
  input  logic [3:0]                 cfg_taps_i,
  output logic [N-1:0]               pe_en_o,
  output logic [N-1:0]               pe_mode_sel_o,
  output logic [N-1:0]               pe_reg_reset_o,
  output logic [SEL_MUX_A_WIDTH-1:0] mux_a_sel_o,
  output logic [SEL_MUX_B_WIDTH-1:0] mux_b_sel_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [PERF_W-1:0]          perf_mac_cycles_o
);

  localparam logic             HAS_DRAIN  = (DRAIN_CYCLES != 0);
  localparam logic [TAP_W-1:0] DRAIN_LAST = HAS_DRAIN ? TAP_W'(DRAIN_CYCLES - 1) : '0;

  npu_seq_state_t state, state_n;
  logic [N-1:0]     mask_q, mask_n;
  logic             mode_q, mode_n;
  logic [TAP_W-1:0] taps_q, taps_n;

  logic             cnt_load, cnt_inc, cnt_last;
  logic [TAP_W-1:0] cnt, cnt_term, tap_nxt;

  logic [N-1:0]               pe_en_n, pe_mode_sel_n, pe_reg_reset_n;
  logic [SEL_MUX_A_WIDTH-1:0] mux_a_n;
  logic [SEL_MUX_B_WIDTH-1:0] mux_b_n;
  logic                       busy_n, done_n;

  // One counter serves both the tap index (MAC) and the drain countdown.
  assign cnt_term = (state == MAC) ? (taps_q - TAP_W'(1)) : DRAIN_LAST;

  npu_seq_tap_counter #(.W(TAP_W)) u_tap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .inc      (cnt_inc),
    .load_val ('0),
    .term_val (cnt_term),
    .count    (cnt),
    .last_c   (cnt_last)
  );

  // Next state and next registered outputs; outputs describe the coming cycle.
  always_comb begin
    state_n        = state;
    mask_n         = mask_q;
    mode_n         = mode_q;
    taps_n         = taps_q;
    cnt_load       = 1'b0;
    cnt_inc        = 1'b0;
    tap_nxt        = '0;
    pe_en_n        = '0;
    pe_reg_reset_n = '0;
    done_n         = 1'b0;
    pe_mode_sel_n  = pe_mode_sel_o;
    mux_a_n        = mux_a_sel_o;
    mux_b_n        = mux_b_sel_o;
    busy_n         = busy_o;

    unique case (state)
      IDLE: begin
        pe_mode_sel_n = '0;
        mux_a_n       = '0;
        mux_b_n       = '0;
        busy_n        = 1'b0;
        if (start_i) begin
          state_n        = CLEAR;
          mask_n         = cfg_mask_i;
          mode_n         = cfg_mode_i;
          taps_n         = clamp_taps(cfg_taps_i);
          pe_reg_reset_n = cfg_mask_i;
          pe_mode_sel_n  = {N{cfg_mode_i}} & cfg_mask_i;
          busy_n         = 1'b1;
        end
      end
      CLEAR: begin
        state_n  = MAC;
        cnt_load = 1'b1;
        tap_nxt  = '0;
        pe_en_n  = mask_q;
        mux_a_n  = SEL_MUX_A_WIDTH'(tap_nxt);
        mux_b_n  = SEL_MUX_B_WIDTH'(tap_nxt)
                 + (mode_q ? SEL_MUX_B_WIDTH'(B_DIRECT_OFFSET) : '0);
      end
      MAC: begin
        if (cnt_last) begin
          cnt_load = 1'b1;
          if (HAS_DRAIN) begin
            state_n = DRAIN;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end else begin
          cnt_inc = 1'b1;
          tap_nxt = cnt + TAP_W'(1);
          pe_en_n = mask_q;
          mux_a_n = SEL_MUX_A_WIDTH'(tap_nxt);
          mux_b_n = SEL_MUX_B_WIDTH'(tap_nxt)
                  + (mode_q ? SEL_MUX_B_WIDTH'(B_DIRECT_OFFSET) : '0);
        end
      end
      DRAIN: begin
        if (cnt_last) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        state_n       = IDLE;
        pe_mode_sel_n = '0;
        mux_a_n       = '0;
        mux_b_n       = '0;
        busy_n        = 1'b0;
      end
      default: state_n = IDLE;
    endcase

    // Abort overrides everything outside IDLE and suppresses done.
    if (abort_i && (state != IDLE)) begin
      state_n        = IDLE;
      pe_en_n        = '0;
      pe_reg_reset_n = '0;
      pe_mode_sel_n  = '0;
      mux_a_n        = '0;
      mux_b_n        = '0;
      busy_n         = 1'b0;
      done_n         = 1'b0;
    end
  end

  // State, latched config and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mask_q         <= '0;
      mode_q         <= 1'b0;
      taps_q         <= '0;
      pe_en_o        <= '0;
      pe_mode_sel_o  <= '0;
      pe_reg_reset_o <= '0;
      mux_a_sel_o    <= '0;
      mux_b_sel_o    <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      state          <= state_n;
      mask_q         <= mask_n;
      mode_q         <= mode_n;
      taps_q         <= taps_n;
      pe_en_o        <= pe_en_n;
      pe_mode_sel_o  <= pe_mode_sel_n;
      pe_reg_reset_o <= pe_reg_reset_n;
      mux_a_sel_o    <= mux_a_n;
      mux_b_sel_o    <= mux_b_n;
      busy_o         <= busy_n;
      done_o         <= done_n;
    end
  end

`ifdef NPU_SEQ_PERF_CNT_EN
  // Saturating count of MAC-state cycles; only rst_n clears it.
  logic [PERF_W-1:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_q <= '0;
    else if ((state == MAC) && (perf_q != '1))
      perf_q <= perf_q + PERF_W'(1);
  end

  assign perf_mac_cycles_o = perf_q;
`else
  assign perf_mac_cycles_o = '0;
`endif

endmodule
